hemaia_clk_div_cfg_sequencer: RTL and testbench

//  Upstream configuration stage for the per-domain clock dividers in hemaia_clk_rst_controller.

---
 rtl/hemaia_clk_rst_pkg.sv | 20 ++
 rtl/hemaia_clk_settle_timer.sv | 41 ++++
 rtl/hemaia_clk_div_cfg_sequencer.sv | 168 ++++++++++++++++
 tb/tb_hemaia_clk_div_cfg_sequencer.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/hemaia_clk_rst_pkg.sv
// Shared types and helpers for the clock/reset controller configuration path.
package hemaia_clk_rst_pkg;

  // Sequencer FSM states.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ISSUE  = 2'd1,
    SETTLE = 2'd2
  } cfg_seq_state_e;

  // Effective division used for settle time: a gated divider (0) still needs one cycle.
  function automatic logic [31:0] eff_div(input logic [31:0] d);
    if (d == 32'd0) begin
      return 32'd1;
    end else begin
      return d;
    end
  endfunction

endpackage

// File: rtl/hemaia_clk_settle_timer.sv
// Down-counting settle timer. A load starts the count; expire is high during the
// cycle in which the count sits at 1, i.e. the last settle cycle.
module hemaia_clk_settle_timer #(
  parameter int unsigned CntWidth = 6
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                load,
  input  logic [CntWidth-1:0] load_value,
  output logic                expire
);

  logic [CntWidth-1:0] count_r;
  logic [CntWidth-1:0] count_next_s;
  logic                expire_r;

  // Next count: load wins, otherwise decrement until zero and hold there.
  always_comb begin
    if (load) begin
      count_next_s = load_value;
    end else if (count_r != {CntWidth{1'b0}}) begin
      count_next_s = count_r - CntWidth'(1);
    end else begin
      count_next_s = count_r;
    end
  end

  // Count register and registered expire flag (high while the count equals 1).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_r  <= {CntWidth{1'b0}};
      expire_r <= 1'b0;
    end else begin
      count_r  <= count_next_s;
      expire_r <= (count_next_s == CntWidth'(1));
    end
  end

  assign expire = expire_r;

endmodule

// File: rtl/hemaia_clk_div_cfg_sequencer.sv
// Serialising configuration stage for the per-domain clock dividers. Accepts one
// divisor change at a time, drives the new word plus a one-cycle strobe, and holds
// off further requests until the divider has had time to apply and settle.
module hemaia_clk_div_cfg_sequencer
  import hemaia_clk_rst_pkg::*;
#(
  parameter int unsigned NumDomains       = 4,
  parameter int unsigned MaxDivisionWidth = 4,
  parameter int unsigned DefaultDivision  = 1,
  parameter int unsigned SettleExtra      = 2,
  // Index port width; the default is the minimum that addresses every domain.
  parameter int unsigned IdxWidth         = (NumDomains > 1) ? $clog2(NumDomains) : 1
) (
  input  logic                                       clk_i,
  input  logic                                       rst_ni,
  input  logic                                       cfg_valid_i,
  output logic                                       cfg_ready_o,
  input  logic [IdxWidth-1:0]                        cfg_idx_i,
  input  logic [MaxDivisionWidth-1:0]                cfg_divisor_i,
  output logic [NumDomains-1:0][MaxDivisionWidth-1:0] divisor_o,
  output logic [NumDomains-1:0]                      divisor_valid_o,
  output logic                                       busy_o,
  output logic                                       done_o,
  output logic                                       err_o
);

  localparam int unsigned CntWidth = MaxDivisionWidth + 2;
  localparam logic [MaxDivisionWidth-1:0] DefaultWord = MaxDivisionWidth'(DefaultDivision);

  cfg_seq_state_e                              state_r;
  cfg_seq_state_e                              state_next_s;
  logic [NumDomains-1:0][MaxDivisionWidth-1:0] divisor_r;
  logic [NumDomains-1:0]                       divisor_valid_r;
  logic [MaxDivisionWidth-1:0]                 old_r;
  logic [MaxDivisionWidth-1:0]                 new_r;
  logic                                        busy_r;
  logic                                        ready_r;
  logic                                        done_r;
  logic                                        err_r;

  logic                        idx_in_range_s;
  logic [NumDomains-1:0]       sel_onehot_s;
  logic [MaxDivisionWidth-1:0] cur_div_s;
  logic                        accept_s;
  logic                        change_s;
  logic                        done_s;
  logic                        err_s;
  logic [NumDomains-1:0]       strobe_s;
  logic                        load_s;
  logic [31:0]                 settle_sum_s;
  logic [CntWidth-1:0]         load_value_s;
  logic                        expire_s;

  // Decode the request index on its full width and fetch the current word of the target.
  always_comb begin
    idx_in_range_s = (32'(cfg_idx_i) < 32'(NumDomains));
    cur_div_s      = {MaxDivisionWidth{1'b0}};
    sel_onehot_s   = {NumDomains{1'b0}};
    for (int unsigned d = 0; d < NumDomains; d++) begin
      sel_onehot_s[d] = (32'(cfg_idx_i) == 32'(d));
      cur_div_s       = cur_div_s | (divisor_r[d] & {MaxDivisionWidth{sel_onehot_s[d]}});
    end
  end

  assign accept_s = cfg_valid_i & (state_r == IDLE);
  assign change_s = accept_s & idx_in_range_s & (cfg_divisor_i != cur_div_s);

  // FSM state register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // FSM next-state logic: only a real divisor change leaves IDLE.
  always_comb begin
    case (state_r)
      IDLE: begin
        if (change_s) begin
          state_next_s = ISSUE;
        end else begin
          state_next_s = IDLE;
        end
      end
      ISSUE: begin
        state_next_s = SETTLE;
      end
      SETTLE: begin
        if (expire_s) begin
          state_next_s = IDLE;
        end else begin
          state_next_s = SETTLE;
        end
      end
      default: begin
        state_next_s = IDLE;
      end
    endcase
  end

  // FSM output logic: next values of the registered handshake/strobe outputs and timer load.
  always_comb begin
    done_s = (accept_s & ~change_s) | ((state_r == SETTLE) & expire_s);
    err_s  = accept_s & ~idx_in_range_s;
    if (state_next_s == ISSUE) begin
      strobe_s = sel_onehot_s;
    end else begin
      strobe_s = {NumDomains{1'b0}};
    end
    load_s       = (state_r == ISSUE);
    settle_sum_s = eff_div(32'(old_r)) + eff_div(32'(new_r)) + 32'(SettleExtra);
    load_value_s = CntWidth'(settle_sum_s);
  end

  // Registered status, handshake and strobe outputs.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      busy_r          <= 1'b0;
      ready_r         <= 1'b1;
      done_r          <= 1'b0;
      err_r           <= 1'b0;
      divisor_valid_r <= {NumDomains{1'b0}};
    end else begin
      busy_r          <= (state_next_s != IDLE);
      ready_r         <= (state_next_s == IDLE);
      done_r          <= done_s;
      err_r           <= err_s;
      divisor_valid_r <= strobe_s;
    end
  end

  // Divisor word array and the old/new pair used for the settle time; written only on accept.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      divisor_r <= {NumDomains{DefaultWord}};
      old_r     <= DefaultWord;
      new_r     <= DefaultWord;
    end else if (change_s) begin
      old_r <= cur_div_s;
      new_r <= cfg_divisor_i;
      for (int unsigned d = 0; d < NumDomains; d++) begin
        if (sel_onehot_s[d]) begin
          divisor_r[d] <= cfg_divisor_i;
        end
      end
    end
  end

  hemaia_clk_settle_timer #(
    .CntWidth (CntWidth)
  ) u_settle_timer (
    .clk        (clk_i),
    .rst_n      (rst_ni),
    .load       (load_s),
    .load_value (load_value_s),
    .expire     (expire_s)
  );

  assign divisor_o       = divisor_r;
  assign divisor_valid_o = divisor_valid_r;
  assign busy_o          = busy_r;
  assign cfg_ready_o     = ready_r;
  assign done_o          = done_r;
  assign err_o           = err_r;

endmodule

// File: tb/tb_hemaia_clk_div_cfg_sequencer.sv
// Self-checking bench: a cycle-count transaction model predicts every output each
// cycle; directed scenarios add literal expectations and a closed-loop divider model.
module tb_hemaia_clk_div_cfg_sequencer;

  localparam int N  = 4;
  localparam int SE = 2;

  logic             clk = 1'b0;
  logic             rst_ni = 1'b0;
  logic             cfg_valid_i = 1'b0;
  logic             cfg_ready_o;
  logic [2:0]       cfg_idx_i = 3'd0;
  logic [3:0]       cfg_divisor_i = 4'd0;
  logic [N-1:0][3:0] divisor_o;
  logic [N-1:0]     divisor_valid_o;
  logic             busy_o;
  logic             done_o;
  logic             err_o;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int last_acc_cyc = 0;
  logic acc;

  hemaia_clk_div_cfg_sequencer #(
    .NumDomains(N), .MaxDivisionWidth(4), .DefaultDivision(1), .SettleExtra(SE), .IdxWidth(3)
  ) dut (
    .clk_i(clk), .rst_ni(rst_ni), .cfg_valid_i(cfg_valid_i), .cfg_ready_o(cfg_ready_o),
    .cfg_idx_i(cfg_idx_i), .cfg_divisor_i(cfg_divisor_i), .divisor_o(divisor_o),
    .divisor_valid_o(divisor_valid_o), .busy_o(busy_o), .done_o(done_o), .err_o(err_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int eff(input int d);
    return (d == 0) ? 1 : d;
  endfunction

  // Reference model: remaining busy cycles plus the divisor each domain should hold.
  int         m_rem;
  logic [3:0] m_div [N];
  logic       e_done, e_err;
  logic [3:0] e_strobe;

  always @(posedge clk or negedge rst_ni) begin
    int ix;
    if (!rst_ni) begin
      m_rem <= 0;
      for (int d = 0; d < N; d++) m_div[d] <= 4'd1;
      e_done <= 1'b0; e_err <= 1'b0; e_strobe <= 4'd0;
    end else begin
      e_done <= 1'b0; e_err <= 1'b0; e_strobe <= 4'd0;
      ix = int'(cfg_idx_i);
      if (m_rem == 0) begin
        if (cfg_valid_i) begin
          if (ix >= N) begin
            e_err <= 1'b1; e_done <= 1'b1;
          end else if (cfg_divisor_i == m_div[ix]) begin
            e_done <= 1'b1;
          end else begin
            m_div[ix] <= cfg_divisor_i;
            m_rem     <= 1 + eff(int'(m_div[ix])) + eff(int'(cfg_divisor_i)) + SE;
            e_strobe  <= 4'(1 << ix);
          end
        end
      end else begin
        m_rem <= m_rem - 1;
        if (m_rem == 1) e_done <= 1'b1;
      end
    end
  end

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    chk("ready", 32'(cfg_ready_o), 32'(m_rem == 0));
    chk("busy", 32'(busy_o), 32'(m_rem != 0));
    chk("done", 32'(done_o), 32'(e_done));
    chk("err", 32'(err_o), 32'(e_err));
    chk("strobe", 32'(divisor_valid_o), 32'(e_strobe));
    for (int d = 0; d < N; d++) chk("divisor", 32'(divisor_o[d]), 32'(m_div[d]));
  end

  // Handshake monitor and cycle counter.
  always @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) acc <= 1'b0;
    else acc <= cfg_valid_i & cfg_ready_o;
  end
  always @(posedge clk) cyc <= cyc + 1;

  // Closed-loop divider model: applies a word on its strobe, emits one pulse per period.
  logic [3:0] app_div [N];
  logic [3:0] dcnt [N];
  logic [N-1:0] pulse;
  always @(posedge clk or negedge rst_ni) begin
    logic [3:0] nxt;
    if (!rst_ni) begin
      for (int d = 0; d < N; d++) begin app_div[d] <= 4'd1; dcnt[d] <= 4'd0; end
      pulse <= '0;
    end else begin
      for (int d = 0; d < N; d++) begin
        if (divisor_valid_o[d]) app_div[d] <= divisor_o[d];
        if (app_div[d] == 4'd0) begin
          pulse[d] <= 1'b0;
        end else begin
          nxt = (32'(dcnt[d]) + 32'd1 >= 32'(app_div[d])) ? 4'd0 : dcnt[d] + 4'd1;
          dcnt[d]  <= nxt;
          pulse[d] <= (nxt == 4'd0);
        end
      end
    end
  end

  task automatic send(input int idx, input int div, input bit hold);
    int n;
    cfg_idx_i = 3'(idx); cfg_divisor_i = 4'(div); cfg_valid_i = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!acc && n < 200);
    chk("accept_timeout", 32'(acc), 32'd1);
    last_acc_cyc = cyc;
    if (!hold) cfg_valid_i = 1'b0;
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (!done_o && n < 100) begin @(negedge clk); n++; end
    chk("done_timeout", 32'(done_o), 32'd1);
  endtask

  initial begin
    int n, a0, cnt3, cnt0;
    // T1 reset
    repeat (3) @(negedge clk);
    #2 rst_ni = 1'b1;
    @(negedge clk);
    chk("t1_divisor", 32'(divisor_o), 32'h1111);
    chk("t1_ready", 32'(cfg_ready_o), 32'd1);
    chk("t1_busy", 32'(busy_o), 32'd0);
    chk("t1_strobe", 32'(divisor_valid_o), 32'd0);

    // T2 1 -> 4 on domain 2
    send(2, 4, 1'b0);
    chk("t2_strobe", 32'(divisor_valid_o), 32'h4);
    n = 0;
    while (busy_o && n < 50) begin n++; @(negedge clk); end
    chk("t2_busy_cycles", 32'(n), 32'd8);
    chk("t2_done", 32'(done_o), 32'd1);
    chk("t2_divisor", 32'(divisor_o[2]), 32'd4);

    // T3 same value
    @(negedge clk);
    send(2, 4, 1'b0);
    chk("t3_done", 32'(done_o), 32'd1);
    chk("t3_busy", 32'(busy_o), 32'd0);
    chk("t3_strobe", 32'(divisor_valid_o), 32'd0);

    // T4 out-of-range index
    @(negedge clk);
    send(5, 7, 1'b0);
    chk("t4_err", 32'(err_o), 32'd1);
    chk("t4_done", 32'(done_o), 32'd1);
    chk("t4_divisor", 32'(divisor_o), 32'h1411);

    // T5 back-to-back with valid held, then closed-loop divider check
    @(negedge clk);
    send(3, 3, 1'b1);
    a0 = last_acc_cyc;
    send(0, 0, 1'b0);
    chk("t5_accept_gap", 32'(last_acc_cyc - a0), 32'd8);
    wait_done();
    repeat (3) @(negedge clk);
    cnt3 = 0; cnt0 = 0;
    repeat (12) begin
      @(negedge clk);
      if (pulse[3]) cnt3++;
      if (pulse[0]) cnt0++;
    end
    chk("t5_div3_pulses", 32'(cnt3), 32'd4);
    chk("t5_gated_pulses", 32'(cnt0), 32'd0);

    // T6 reset during SETTLE of an 8 -> 15 change
    send(1, 8, 1'b0);
    wait_done();
    @(negedge clk);
    send(1, 15, 1'b0);
    repeat (5) @(negedge clk);
    chk("t6_busy_before", 32'(busy_o), 32'd1);
    #2 rst_ni = 1'b0;
    #1;
    chk("t6_divisor", 32'(divisor_o), 32'h1111);
    chk("t6_busy", 32'(busy_o), 32'd0);
    chk("t6_ready", 32'(cfg_ready_o), 32'd1);
    chk("t6_strobe", 32'(divisor_valid_o), 32'd0);
    @(negedge clk);
    #2 rst_ni = 1'b1;
    @(negedge clk);
    send(1, 15, 1'b0);
    chk("t6_strobe_after", 32'(divisor_valid_o), 32'h2);
    wait_done();
    chk("t6_divisor_after", 32'(divisor_o[1]), 32'd15);

    // Randomized traffic, valid held stable until accepted
    for (int i = 0; i < 600; i++) begin
      if (!cfg_valid_i || acc) begin
        if ($urandom_range(0, 3) == 0) begin
          cfg_valid_i = 1'b0;
        end else begin
          cfg_valid_i   = 1'b1;
          cfg_idx_i     = 3'($urandom_range(0, 5));
          cfg_divisor_i = 4'($urandom_range(0, 15));
          if (cfg_idx_i < 3'd4 && $urandom_range(0, 3) == 0)
            cfg_divisor_i = m_div[int'(cfg_idx_i)];
        end
      end
      @(negedge clk);
    end
    cfg_valid_i = 1'b0;
    repeat (40) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
